// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers shared by the Gray pointer sender and receiver.
// Functions work on up to GRAY_MAX_WIDTH bits; callers zero-extend and slice.
package gray_pkg;

   localparam int GRAY_MAX_WIDTH = 32;

   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down, done as a log-depth shift cascade.
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
      logic [GRAY_MAX_WIDTH-1:0] bin;
      bin = gray;
      for (int i = 0; i < 5; i++) begin
         bin = bin ^ (bin >> (1 << i));
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-bit synchronizer for a Gray-coded bus: a bare flop chain with nothing
// between stages, so CDC tools can recognise and waive it by module name.
module gray_sync #(
   parameter int width       = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [width-1:0] async_in,
   output logic [width-1:0] sync_out
);

   logic [width-1:0] stage [SYNC_STAGES];

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its predecessor's pre-edge value, giving a true shift chain.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign sync_out = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Read side of a dual-clock FIFO: synchronizes the remote Gray write pointer,
// keeps the local read pointer and reports fill level. Link checking is built
// only when GRAY_PTR_RX_CHECK_EN is defined.
module gray_ptr_receiver
   import gray_pkg::*;
#(
   parameter int width       = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [width-1:0] remoteGray,
   input  logic             localAdvance__ENA,
   output logic             localAdvance__RDY,
   output logic [width-1:0] readRemoteBin,
   output logic             readRemoteBin__RDY,
   output logic [width-1:0] localGray,
   output logic [width-1:0] level,
   output logic             empty,
   input  logic             errorClear__ENA,
   output logic             rxError
);

   logic [width-1:0] syncGray;
   logic [width-1:0] decodedBin;
   logic [width-1:0] remoteBin;
   logic [width-1:0] localBin;
   logic [width-1:0] nextLocalBin;
   logic             remoteLoad;
   logic             advance;

   gray_sync #(
      .width       (width),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK      (CLK),
      .nRST     (nRST),
      .async_in (remoteGray),
      .sync_out (syncGray)
   );

   assign decodedBin   = width'(gray2bin(GRAY_MAX_WIDTH'(syncGray)));
   assign nextLocalBin = localBin + width'(1);
   assign advance      = localAdvance__ENA && localAdvance__RDY;

`ifdef GRAY_PTR_RX_CHECK_EN
   logic [width-1:0] prevGray;
   logic [width-1:0] grayDiff;
   logic             linkFault;

   // A legal Gray step flips at most one bit; x & (x-1) is nonzero iff >1 bit set.
   assign grayDiff   = syncGray ^ prevGray;
   assign linkFault  = (grayDiff & (grayDiff - width'(1))) != '0;
   assign remoteLoad = !linkFault;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         prevGray <= '0;
         rxError  <= 1'b0;
      end else begin
         prevGray <= syncGray;
         if (linkFault) begin
            rxError <= 1'b1;
         end else if (errorClear__ENA) begin
            rxError <= 1'b0;
         end
      end
   end
`else
   logic unused_error_clear;

   assign unused_error_clear = errorClear__ENA;
   assign remoteLoad         = 1'b1;
   assign rxError            = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         remoteBin <= '0;
         localBin  <= '0;
         localGray <= '0;
      end else begin
         if (remoteLoad) begin
            remoteBin <= decodedBin;
         end
         if (advance) begin
            localBin  <= nextLocalBin;
            localGray <= width'(bin2gray(GRAY_MAX_WIDTH'(nextLocalBin)));
         end
      end
   end

   // Modular subtraction; values above half range mean the remote overran us.
   assign level              = remoteBin - localBin;
   assign empty              = (level == '0);
   assign localAdvance__RDY  = !empty;
   assign readRemoteBin      = remoteBin;
   assign readRemoteBin__RDY = 1'b1;

endmodule
